// File: rtl/serv_wake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serv_wake_pkg
// Description : Shared FSM state encoding and counter sizing for the
//               serv_wake_ctrl sleep/wake controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serv_wake_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } wake_state_t;

    // Wide enough to hold WAKE_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int wake_cycles);
        return (wake_cycles < 1) ? 1 : $clog2(wake_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : serv_irq_sync
// Description : Per-bit two-flop synchronizer, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/serv_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serv_wake_ctrl
// Description : Core sleep/wake controller: drains the core, gates its clock
//               and restores it WAKE_CYCLES after an enabled interrupt.
//               Define SERV_WAKE_SYNC_EN to synchronize i_irq (2 flops).
// Revision    : 1.0 - initial release
// ============================================================================
module serv_wake_ctrl
    import serv_wake_pkg::*;
#(
    parameter int NUM_IRQ     = 2,
    parameter int WAKE_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    input  logic               i_sleep_req,
    input  logic               i_idle,
    output logic               o_clk_halt,
    output logic               o_sleep_ack,
    output logic               o_wake_valid,
    output logic [NUM_IRQ-1:0] o_wake_src
);

    localparam int                 c_cnt_w    = cnt_width(WAKE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAKE_CYCLES);

    wake_state_t        r_state;
    wake_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_clk_halt;
    logic [NUM_IRQ-1:0] r_wake_src;
    logic [NUM_IRQ-1:0] w_irq;
    logic               w_wake;
    logic               w_sleep_ack;
    logic               w_wake_valid;

`ifdef SERV_WAKE_SYNC_EN
    serv_irq_sync #(
        .WIDTH (NUM_IRQ)
    ) u_irq_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_irq),
        .o_q     (w_irq)
    );
`else
    assign w_irq = i_irq;
`endif

    assign w_wake = |(w_irq & i_irq_mask);

    always_comb begin
        w_state_nxt  = r_state;
        w_sleep_ack  = 1'b0;
        w_wake_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_sleep_req && !w_wake) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A pending wake beats a quiescent core: never sleep over it.
                if (w_wake || !i_sleep_req) begin
                    w_state_nxt = ST_RUN;
                end else if (i_idle) begin
                    w_state_nxt = ST_SLEEP;
                    w_sleep_ack = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (w_wake) begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_RUN;
                    w_wake_valid = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_clk_halt <= 1'b0;
            r_wake_src <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_halt <= (w_state_nxt == ST_SLEEP) || (w_state_nxt == ST_WAKE);
            if (r_state == ST_SLEEP && w_wake) begin
                r_cnt <= c_cnt_load;
            end else if (r_state == ST_WAKE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_sleep_ack) begin
                r_wake_src <= '0;
            end else if (r_state == ST_SLEEP && w_wake) begin
                r_wake_src <= w_irq & i_irq_mask;
            end
        end
    end

    assign o_clk_halt   = r_clk_halt;
    assign o_sleep_ack  = w_sleep_ack;
    assign o_wake_valid = w_wake_valid;
    assign o_wake_src   = r_wake_src;

endmodule
`default_nettype wire

// File: tb/tb_serv_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serv_wake_ctrl
// Description : Scoreboard bench for serv_wake_ctrl (NUM_IRQ=4, WAKE_CYCLES=3)
//               plus a WAKE_CYCLES=0 instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_wake_ctrl;

    localparam int C_N = 4;
    localparam logic [1:0] EV_ACK  = 2'd0;
    localparam logic [1:0] EV_RISE = 2'd1;
    localparam logic [1:0] EV_FALL = 2'd2;
    localparam logic [1:0] EV_WV   = 2'd3;

    typedef struct {
        logic [1:0]     kind;
        int             cyc;
        logic [C_N-1:0] data;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [C_N-1:0] irq = '0;
    logic [C_N-1:0] mask = 4'hF;
    logic           sleep_req = 1'b0;
    logic           idle = 1'b1;
    logic           halt, ack, wv;
    logic [C_N-1:0] src;
    logic           halt0, ack0, wv0;
    logic [C_N-1:0] src0;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    logic prev_halt = 1'b0;

    serv_wake_ctrl #(.NUM_IRQ(C_N), .WAKE_CYCLES(3)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq        (irq),
        .i_irq_mask   (mask),
        .i_sleep_req  (sleep_req),
        .i_idle       (idle),
        .o_clk_halt   (halt),
        .o_sleep_ack  (ack),
        .o_wake_valid (wv),
        .o_wake_src   (src)
    );

    serv_wake_ctrl #(.NUM_IRQ(C_N), .WAKE_CYCLES(0)) u_dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq        (irq),
        .i_irq_mask   (mask),
        .i_sleep_req  (sleep_req),
        .i_idle       (idle),
        .o_clk_halt   (halt0),
        .o_sleep_ack  (ack0),
        .o_wake_valid (wv0),
        .o_wake_src   (src0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input int at, input logic [C_N-1:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] kind, input logic [C_N-1:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind %0d data %0h at cycle %0d", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
                errors++;
                $display("FAIL event: got kind %0d cyc %0d data %0h expected kind %0d cyc %0d data %0h",
                         kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every output event on the main DUT is matched against the queue.
    always @(negedge clk) begin
        if (ack === 1'b1) observe(EV_ACK, '0);
        if (wv === 1'b1) observe(EV_WV, src);
        if (halt !== prev_halt) observe(halt ? EV_RISE : EV_FALL, '0);
        prev_halt <= halt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int m;
        sleep_req = 1'b1;
        idle      = 1'b1;
        irq       = '0;
        mask      = 4'hF;
        #1 rst_n  = 1'b0;
        ticks(2);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_wv", {31'd0, wv}, 32'd0);
        chk("rst_src", {28'd0, src}, 32'd0);
        chk("rst_halt0", {31'd0, halt0}, 32'd0);

        // Held sleep request enters DRAIN on the first edge after release.
        n = cyc;
        rst_n = 1'b1;
        expect_ev(EV_ACK, n + 1, '0);
        expect_ev(EV_RISE, n + 2, '0);
        ticks(2);
        sleep_req = 1'b0;
        ticks(2);

        // Single-cycle irq wakes; WAKE_CYCLES=0 instance checked directly.
        m = cyc;
        irq = 4'b0100;
        expect_ev(EV_WV, m + 4, 4'b0100);
        expect_ev(EV_FALL, m + 5, '0);
        tick();
        irq = '0;
        chk("wc0_halt_in_wake", {31'd0, halt0}, 32'd1);
        chk("wc0_wv", {31'd0, wv0}, 32'd1);
        chk("wc0_src", {28'd0, src0}, 32'h4);
        tick();
        chk("wc0_halt_released", {31'd0, halt0}, 32'd0);
        chk("wc0_wv_single", {31'd0, wv0}, 32'd0);
        ticks(4);

        // Masked source must not wake; enabling the mask then does.
        n = cyc;
        sleep_req = 1'b1;
        expect_ev(EV_ACK, n + 1, '0);
        expect_ev(EV_RISE, n + 2, '0);
        ticks(2);
        sleep_req = 1'b0;
        chk("src_cleared_on_sleep", {28'd0, src}, 32'd0);
        mask = 4'b1101;
        irq  = 4'b0010;
        ticks(3);
        m = cyc;
        mask = 4'hF;
        expect_ev(EV_WV, m + 4, 4'b0010);
        expect_ev(EV_FALL, m + 5, '0);
        tick();
        irq = '0;
        ticks(5);

        // DRAIN with busy core, then wake together with idle: back to RUN.
        sleep_req = 1'b1;
        idle      = 1'b0;
        ticks(2);
        irq  = 4'b0001;
        idle = 1'b1;
        ticks(2);
        chk("drain_abort_halt", {31'd0, halt}, 32'd0);
        sleep_req = 1'b0;
        irq       = '0;
        ticks(2);

        // DRAIN abandoned by dropping the request in the same cycle idle rises.
        sleep_req = 1'b1;
        idle      = 1'b0;
        ticks(2);
        sleep_req = 1'b0;
        idle      = 1'b1;
        ticks(3);

        // Asynchronous reset two cycles into WAKE.
        n = cyc;
        sleep_req = 1'b1;
        expect_ev(EV_ACK, n + 1, '0);
        expect_ev(EV_RISE, n + 2, '0);
        ticks(2);
        sleep_req = 1'b0;
        tick();
        m = cyc;
        irq = 4'b0010;
        tick();
        irq = '0;
        tick();
        expect_ev(EV_FALL, m + 2, '0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_halt", {31'd0, halt}, 32'd0);
        chk("async_rst_src", {28'd0, src}, 32'd0);
        chk("async_rst_wv", {31'd0, wv}, 32'd0);
        ticks(3);
        rst_n = 1'b1;
        ticks(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serv_wake_ctrl.md
SERV_WAKE_CTRL -- requirements
Module: serv_wake_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 2, number of wake-capable interrupt lines (range 1..32).
REQ-002 SHALL have parameter WAKE_CYCLES, default 4, clock-enable restore delay in cycles after a wake event (range 0..255).
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_irq  input  NUM_IRQ  level interrupt lines, one bit per source.
REQ-006 SHALL have port i_irq_mask  input  NUM_IRQ  per-source wake enable, 1 = enabled.
REQ-007 SHALL have port i_sleep_req  input  1  level sleep request from the core (WFI).
REQ-008 SHALL have port i_idle  input  1  core quiescent: no bus transaction outstanding.
REQ-009 SHALL have port o_clk_halt  output  1  registered clock-gate request to the core.
REQ-010 SHALL have port o_sleep_ack  output  1  one-cycle pulse on sleep entry.
REQ-011 SHALL have port o_wake_valid  output  1  one-cycle pulse when the core clock is restored.
REQ-012 SHALL have port o_wake_src  output  NUM_IRQ  masked sources that caused the last wake.

Function
REQ-013 SHALL define wake = |(i_irq & i_irq_mask), an OR over enabled sources.
REQ-014 SHALL implement FSM states RUN, DRAIN, SLEEP and WAKE.
REQ-015 RUN: SHALL go to DRAIN when i_sleep_req=1 and wake=0; when wake=1 the request SHALL be ignored.
REQ-016 DRAIN: SHALL go to SLEEP on i_idle=1 with wake=0, pulse o_sleep_ack in the same cycle, and clear o_wake_src.
REQ-017 DRAIN: SHALL return to RUN on wake=1 or i_sleep_req=0, with no ack; wake takes priority over i_idle.
REQ-018 SLEEP: o_clk_halt SHALL be 1; on wake=1 SHALL latch o_wake_src <= i_irq & i_irq_mask, load the counter with WAKE_CYCLES and go to WAKE.
REQ-019 WAKE: SHALL decrement the counter each cycle with o_clk_halt held at 1; at counter==0 SHALL go to RUN and pulse o_wake_valid.
REQ-020 WAKE: irq deassertion SHALL NOT abort the wake sequence; sleep requests are ignored until RUN.
REQ-021 o_clk_halt SHALL be a flop equal to 1 exactly in SLEEP and WAKE, asserted the cycle after DRAIN->SLEEP and released the cycle after WAKE->RUN.
REQ-022 WAKE_CYCLES=0: SHALL spend exactly one cycle in WAKE.
REQ-023 Counter width SHALL be max(1, $clog2(WAKE_CYCLES+1)) bits, with no wrap below zero.
REQ-024 Latency from i_sleep_req with i_idle=1 already high to o_clk_halt=1 SHALL be 2 cycles.
REQ-025 Latency from wake in SLEEP to o_clk_halt=0 SHALL be WAKE_CYCLES+2 cycles.

Reset
REQ-026 i_rst_n=0 SHALL immediately force RUN, counter=0, o_clk_halt=0, o_sleep_ack=0, o_wake_valid=0 and o_wake_src=0, independent of i_clk.
REQ-027 Reset in SLEEP or WAKE SHALL release o_clk_halt asynchronously, with no o_wake_valid pulse.
REQ-028 Reset deassertion SHALL leave the FSM in RUN; a held i_sleep_req SHALL re-enter DRAIN on the first clock after release.

Configuration
REQ-029 With SERV_WAKE_SYNC_EN defined, i_irq SHALL pass through a 2-flop synchronizer per bit before masking, adding 2 cycles to the wake latency and to the RUN/DRAIN abort.
REQ-030 Without SERV_WAKE_SYNC_EN, i_irq SHALL be used directly and SHALL be synchronous to i_clk.

Structure
REQ-031 Package serv_wake_pkg SHALL hold the FSM state enum (2-bit) and the counter width function.
REQ-032 Submodule serv_irq_sync SHALL implement the parametrised-width 2-flop synchronizer with async active-low reset, instantiated only under SERV_WAKE_SYNC_EN.

Verification (NUM_IRQ=4, WAKE_CYCLES=3, sync off)
REQ-033 Reset with i_sleep_req=1, i_idle=1, i_irq=0, mask=4'hF -> o_sleep_ack pulse at cycle 1, o_clk_halt=1 at cycle 2.
REQ-034 In SLEEP, i_irq=4'b0100 for 1 cycle -> o_wake_src=4'b0100, o_clk_halt=0 after 5 cycles, one o_wake_valid pulse.
REQ-035 In SLEEP, i_irq=4'b0010 with mask=4'b1101 -> stays in SLEEP; mask becomes 4'b1111 -> wake with o_wake_src=4'b0010.
REQ-036 i_idle=0 in DRAIN, then i_irq=4'b0001 -> back to RUN, no o_sleep_ack, o_clk_halt never asserted.
REQ-037 i_rst_n low mid-WAKE (counter=2) -> o_clk_halt=0 with no clock edge, o_wake_src=0, no o_wake_valid.
REQ-038 WAKE_CYCLES=0 build, wake in SLEEP -> o_clk_halt falls 2 cycles after irq; with SERV_WAKE_SYNC_EN, 4 cycles.
